mem_arbiter: RTL

Two-port round-robin arbiter that shares the single cache/RAM memory subsystem (cache_top + ram behind the `we`/`re`/`done`/`op_in_progress` handshake) between two independent requesters, e.g. instruction fetch (port 0) and data access (port 1). It serializes requests, issues each one downstream as a one-cycle strobe, waits for completion, and returns read data and a completion pulse to the owning requester. A watchdog aborts a request whose `done` never arrives.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single strobe/done memory subsystem.
// Serializes requests, issues one-cycle strobes, returns data/completion, aborts on timeout.
module mem_arbiter #(
    parameter int WIDTH     = 8,
    parameter int RAM_DEPTH = 256,
    parameter int TIMEOUT   = 64,
    localparam int ADDR_W   = $clog2(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_re,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [WIDTH-1:0]  p0_wdata,
    input  logic              p1_re,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [WIDTH-1:0]  p1_wdata,
    output logic              p0_done,
    output logic              p0_err,
    output logic [WIDTH-1:0]  p0_rdata,
    output logic              p1_done,
    output logic              p1_err,
    output logic [WIDTH-1:0]  p1_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_done,
    input  logic              mem_busy
);

    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_d;
    logic              last_grant, last_grant_d;
    logic              grant, grant_d;
    logic              op_write, op_write_d;
    logic [WD_W-1:0]   wd, wd_d;
    logic              mem_re_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [WIDTH-1:0]  mem_wdata_d;
    logic              p0_done_d, p0_err_d, p1_done_d, p1_err_d;
    logic [WIDTH-1:0]  p0_rdata_d, p1_rdata_d;
    logic              req0, req1, pick;

    assign req0 = p0_re | p0_we;
    assign req1 = p1_re | p1_we;

    // All outputs are computed one cycle ahead so every port is a flop output.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state;
        last_grant_d = last_grant;
        grant_d      = grant;
        op_write_d   = op_write;
        wd_d         = wd;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        p0_done_d    = 1'b0;
        p0_err_d     = 1'b0;
        p1_done_d    = 1'b0;
        p1_err_d     = 1'b0;
        p0_rdata_d   = p0_rdata;
        p1_rdata_d   = p1_rdata;
        pick         = 1'b0;

        case (state)
            IDLE: begin
                if (!mem_busy && (req0 || req1)) begin
                    pick         = (req0 && req1) ? ~last_grant : req1;
                    grant_d      = pick;
                    last_grant_d = pick;
                    op_write_d   = pick ? p1_we : p0_we;
                    mem_addr_d   = pick ? p1_addr : p0_addr;
                    mem_wdata_d  = pick ? p1_wdata : p0_wdata;
                    mem_we_d     = op_write_d;
                    mem_re_d     = ~op_write_d;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_done) begin
                    if (!op_write) begin
                        if (grant) p1_rdata_d = mem_rdata;
                        else       p0_rdata_d = mem_rdata;
                    end
                    p0_done_d = ~grant;
                    p1_done_d = grant;
                    state_d   = RESP;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    p0_done_d = ~grant;
                    p1_done_d = grant;
                    p0_err_d  = ~grant;
                    p1_err_d  = grant;
                    state_d   = RESP;
                end else begin
                    wd_d = wd + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            op_write   <= 1'b0;
            wd         <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            p0_done    <= 1'b0;
            p0_err     <= 1'b0;
            p1_done    <= 1'b0;
            p1_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            grant      <= grant_d;
            op_write   <= op_write_d;
            wd         <= wd_d;
            mem_re     <= mem_re_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            p0_done    <= p0_done_d;
            p0_err     <= p0_err_d;
            p1_done    <= p1_done_d;
            p1_err     <= p1_err_d;
            p0_rdata   <= p0_rdata_d;
            p1_rdata   <= p1_rdata_d;
        end
    end

endmodule
